encoder4_2_sync: RTL and testbench

//   Registered 4-to-2 priority encoder: inverse of the 2-to-4 decoder. Accepts a

---
 rtl/encoder4_2_sync_if.sv | 33 +++
 rtl/encoder4_2_sync.sv | 105 ++++++++++
 tb/tb_encoder4_2_sync.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/encoder4_2_sync_if.sv
// ---------------------------------------------------------------------------
// encoder4_2_sync_if
//   Handshake bundle for the registered 4-to-2 priority encoder.
//   Input side : in_valid / in_ready / d       (producer -> encoder)
//   Output side: out_valid / out_ready / a / v / multi, plus err_cnt
//   Modports   : slave  = the encoder itself
//                master = the environment (producer and consumer together)
// ---------------------------------------------------------------------------
interface encoder4_2_sync_if #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     d;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     a;
    logic             v;
    logic             multi;
    logic [CNT_W-1:0] err_cnt;

    modport slave (
        input  in_valid, d, out_ready,
        output in_ready, out_valid, a, v, multi, err_cnt
    );

    modport master (
        output in_valid, d, out_ready,
        input  in_ready, out_valid, a, v, multi, err_cnt
    );
endinterface

// File: rtl/encoder4_2_sync.sv
// ---------------------------------------------------------------------------
// encoder4_2_sync
//   Registered priority encoder over a valid/ready handshake. An accepted line
//   vector d is turned into the index of its highest set bit (a), an "any bit
//   set" flag (v) and a "two or more bits set" flag (multi). Multi-hot words
//   are counted in a saturating error counter.
//   Ports:
//     clk  in  clock, rising edge
//     rst  in  synchronous reset, active-high
//     en   in  0 = accept nothing; a held output beat still drains
//     bus  encoder4_2_sync_if.slave (handshake, d in; a/v/multi/err_cnt out)
//   One output register: EMPTY (no result held) or FULL (result held).
// ---------------------------------------------------------------------------
module encoder4_2_sync #(
    parameter int N     = 4,
    parameter int W     = 2,
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    encoder4_2_sync_if.slave    bus
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic             v_q, v_d;
    logic             multi_q, multi_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept;
    logic             drain;
    logic [W-1:0]     enc_idx;
    logic [W:0]       enc_pop;

    // Priority encode and popcount of the incoming word. The ascending loop
    // lets the highest set bit overwrite lower ones, giving it priority.
    // NOTE: every variable assigned in always_comb gets a default first;
    // a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        enc_idx = '0;
        enc_pop = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.d[i]) begin
                enc_idx = W'(i);
            end
            enc_pop = enc_pop + (W+1)'(bus.d[i]);
        end
    end

    // Ready whenever the output register is free or being emptied this edge;
    // forced low during reset so nothing is taken while state is cleared.
    assign bus.in_ready = en & ~rst & ((state_q == EMPTY) | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign drain        = (state_q == FULL) & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        v_d       = v_q;
        multi_d   = multi_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            // Covers both EMPTY->FULL and back-to-back drain+accept.
            state_d = FULL;
            a_d     = enc_idx;
            v_d     = (enc_pop != '0);
            multi_d = (enc_pop >= (W+1)'(2));
            if ((enc_pop >= (W+1)'(2)) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (drain) begin
            // a/v/multi keep their last value; only out_valid drops.
            state_d = EMPTY;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            a_q       <= '0;
            v_q       <= 1'b0;
            multi_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            v_q       <= v_d;
            multi_q   <= multi_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.a         = a_q;
    assign bus.v         = v_q;
    assign bus.multi     = multi_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_encoder4_2_sync.sv
// ---------------------------------------------------------------------------
// tb_encoder4_2_sync
//   Self-checking bench for encoder4_2_sync. Expected results are queued when
//   a word is accepted and compared when the consumer takes the beat.
// ---------------------------------------------------------------------------
module tb_encoder4_2_sync;
    localparam int N     = 4;
    localparam int W     = 2;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst;
    logic en;

    always #5 clk = ~clk;

    encoder4_2_sync_if #(.N(N), .W(W), .CNT_W(CNT_W)) bus ();

    encoder4_2_sync #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [1:0] a;
        logic       v;
        logic       multi;
    } res_t;

    typedef struct {
        logic [3:0] d;
        res_t       exp;
    } vec_t;

    res_t sb_q[$];
    int   err_model;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: explicit priority chain and $countones.
    function automatic res_t ref_enc(input logic [3:0] d);
        res_t r;
        if (d[3])      r.a = 2'd3;
        else if (d[2]) r.a = 2'd2;
        else if (d[1]) r.a = 2'd1;
        else           r.a = 2'd0;
        r.v     = (d != 4'b0000);
        r.multi = ($countones(d) >= 2);
        return r;
    endfunction

    // One clock: sample just before the edge (inputs settled), update the
    // model with what happens on that edge, then return 1 time unit after it.
    task automatic tick(input res_t exp);
        logic exp_ready;
        res_t e;
        #1;
        exp_ready = en && !rst && (sb_q.size() == 0 || bus.out_ready);
        check("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (rst) begin
            sb_q.delete();
            err_model = 0;
        end else begin
            check("out_valid", 32'(bus.out_valid), 32'(sb_q.size() != 0));
            check("err_cnt", 32'(bus.err_cnt), 32'(err_model));
            if (sb_q.size() != 0 && bus.out_ready) begin
                e = sb_q.pop_front();
                check("a", 32'(bus.a), 32'(e.a));
                check("v", 32'(bus.v), 32'(e.v));
                check("multi", 32'(bus.multi), 32'(e.multi));
            end
            if (bus.in_valid && exp_ready) begin
                sb_q.push_back(exp);
                if (exp.multi && err_model < 255) err_model++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] d, input logic iv, input logic ordy);
        bus.d         = d;
        bus.in_valid  = iv;
        bus.out_ready = ordy;
        tick(ref_enc(d));
    endtask

    initial begin
        vec_t vecs[9];
        logic [3:0] rd;

        n_checks  = 0;
        n_fail    = 0;
        err_model = 0;

        vecs[0] = '{4'b0001, '{2'd0, 1'b1, 1'b0}};
        vecs[1] = '{4'b0010, '{2'd1, 1'b1, 1'b0}};
        vecs[2] = '{4'b0100, '{2'd2, 1'b1, 1'b0}};
        vecs[3] = '{4'b1000, '{2'd3, 1'b1, 1'b0}};
        vecs[4] = '{4'b1010, '{2'd3, 1'b1, 1'b1}};
        vecs[5] = '{4'b0110, '{2'd2, 1'b1, 1'b1}};
        vecs[6] = '{4'b0011, '{2'd1, 1'b1, 1'b1}};
        vecs[7] = '{4'b1111, '{2'd3, 1'b1, 1'b1}};
        vecs[8] = '{4'b0000, '{2'd0, 1'b0, 1'b0}};

        // Reset held two cycles with a word offered.
        rst = 1'b1;
        en  = 1'b1;
        drive(4'b1000, 1'b1, 1'b1);
        drive(4'b1000, 1'b1, 1'b1);
        rst = 1'b0;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'd0);
        check("rst_a", 32'(bus.a), 32'd0);
        check("rst_v", 32'(bus.v), 32'd0);
        check("rst_multi", 32'(bus.multi), 32'd0);

        // Table sweep, back-to-back with the consumer always ready.
        for (int i = 0; i < 9; i++) begin
            bus.d         = vecs[i].d;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            tick(vecs[i].exp);
        end
        drive(4'b0000, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b1);

        // Round trip through a decoder2_4 model.
        for (int k = 0; k < 4; k++) begin
            bus.d         = 4'b0001 << k;
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            tick('{2'(k), 1'b1, 1'b0});
        end
        bus.d = 4'b0000;
        tick('{2'd0, 1'b0, 1'b0});
        drive(4'b0000, 1'b0, 1'b1);

        // Backpressure: hold the beat for 5 cycles, then drain+accept.
        drive(4'b0100, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 1'b1, 1'b0);
            check("held_a", 32'(bus.a), 32'd2);
            check("held_valid", 32'(bus.out_valid), 32'd1);
            check("held_in_ready", 32'(bus.in_ready), 32'd0);
        end
        drive(4'b0001, 1'b1, 1'b1);
        check("next_a", 32'(bus.a), 32'd0);
        check("next_valid", 32'(bus.out_valid), 32'd1);
        drive(4'b0000, 1'b0, 1'b1);

        // Multi-hot counting and saturation, from a clean counter.
        rst = 1'b1;
        drive(4'b0000, 1'b0, 1'b1);
        rst = 1'b0;
        drive(4'b1010, 1'b1, 1'b1);
        check("mh_a", 32'(bus.a), 32'd3);
        check("mh_multi", 32'(bus.multi), 32'd1);
        check("mh_err_cnt", 32'(bus.err_cnt), 32'd1);
        for (int k = 0; k < 300; k++) begin
            do rd = 4'($urandom_range(0, 15)); while ($countones(rd) < 2);
            drive(rd, 1'b1, 1'b1);
        end
        check("err_sat", 32'(bus.err_cnt), 32'd255);
        drive(4'b0000, 1'b0, 1'b1);

        // EN=0 blocks acceptance.
        en = 1'b0;
        drive(4'b0100, 1'b1, 1'b1);
        drive(4'b0100, 1'b1, 1'b1);
        check("en0_valid", 32'(bus.out_valid), 32'd0);
        en = 1'b1;

        // Reset while a beat is stalled discards it.
        drive(4'b1000, 1'b1, 1'b0);
        drive(4'b0000, 1'b0, 1'b0);
        rst = 1'b1;
        drive(4'b0001, 1'b1, 1'b0);
        rst = 1'b0;
        check("rst_stall_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stall_err", 32'(bus.err_cnt), 32'd0);
        drive(4'b0000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
